// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neural-network blocks: the LIF neuron
// FSM state encoding, the time-step stamp width and the default weight width.
package snn_pkg;

    // Neuron step sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAK  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_FIRE  = 2'd3
    } lif_state_e;

    // Width of the global time-step stamp shared with the STDP units
    localparam int TIME_STEP_W = 8;

    // Default synaptic weight width
    localparam int WEIGHT_SIZE_DEF = 16;

endpackage : snn_pkg

// File: rtl/snn_sat_add.sv
// Unsigned saturating adder: A_W-bit accumulator plus zero-extended B_W-bit
// operand. The result clamps at all-ones instead of wrapping. Shared by the
// LIF neuron and the STDP weight-update blocks. Requires A_W >= B_W.
module snn_sat_add #(
    parameter int A_W = 24,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum
);

    logic [A_W:0] full_sum;

    // Add with one carry bit, clamp to all-ones when the carry is set
    always_comb begin
        full_sum = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
        sum      = full_sum[A_W] ? {A_W{1'b1}} : full_sum[A_W-1:0];
    end

endmodule : snn_sat_add

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron core. One time step runs
// IDLE -> LEAK -> ACCUM (one input per cycle) -> FIRE -> IDLE, or
// IDLE -> FIRE directly while the neuron is refractory. Owns the global
// time_step counter consumed by the STDP units.
// Handshake: step_start is sampled only in IDLE; once accepted, busy rises the
// next cycle and falls in the step_done cycle, which is itself an IDLE cycle,
// so a step_start there is accepted (back-to-back). step_start while busy is
// dropped, never queued. weights must be held stable while busy.
// Build option: define LIF_LEAK_EN to apply the membrane leak in the LEAK
// state; without it the LEAK state still costs one cycle but holds the membrane.
module lif_neuron_core
    import snn_pkg::*;
#(
    parameter int N_INPUTS    = 8,
    parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
    parameter int MEM_SIZE    = 24,
    parameter int THRESHOLD   = 1000,
    parameter int LEAK_SHIFT  = 3,
    parameter int REFRACTORY  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            step_start,
    input  logic [N_INPUTS-1:0]             spk_in,
    input  logic [N_INPUTS*WEIGHT_SIZE-1:0] weights,
    output logic                            busy,
    output logic                            step_done,
    output logic                            spk_post,
    output logic [TIME_STEP_W-1:0]          time_step,
    output logic [MEM_SIZE-1:0]             membrane
);

    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int REFR_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_INPUTS - 1);
    localparam logic [REFR_W-1:0]   REFR_INIT = REFR_W'(REFRACTORY);
    localparam logic [MEM_SIZE-1:0] THRESH_M  = MEM_SIZE'(THRESHOLD);

`ifdef LIF_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    lif_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_INPUTS-1:0]        spk_lat_q, spk_lat_d;
    logic [MEM_SIZE-1:0]        mem_q, mem_d;
    logic [REFR_W-1:0]          refr_q, refr_d;
    logic [TIME_STEP_W-1:0]     ts_q, ts_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       spk_post_q, spk_post_d;

    logic [WEIGHT_SIZE-1:0]     w_arr [N_INPUTS];
    logic [WEIGHT_SIZE-1:0]     cur_w;
    logic [MEM_SIZE-1:0]        mem_plus_w;
    logic [MEM_SIZE-1:0]        leak_amt;

    // Unpack the flattened weight bus and pick the weight of the current input
    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            w_arr[i] = weights[i*WEIGHT_SIZE +: WEIGHT_SIZE];
        end
        cur_w = w_arr[idx_q];
    end

    snn_sat_add #(
        .A_W (MEM_SIZE),
        .B_W (WEIGHT_SIZE)
    ) u_sat_add (
        .a   (mem_q),
        .b   (cur_w),
        .sum (mem_plus_w)
    );

    // Leak amount; zero when the leak is compiled out
    always_comb begin
        leak_amt = LEAK_ON ? (mem_q >> LEAK_SHIFT) : '0;
    end

    // Next-state logic for the step sequencer and all registered outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        spk_lat_d  = spk_lat_q;
        mem_d      = mem_q;
        refr_d     = refr_q;
        ts_d       = ts_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        spk_post_d = 1'b0;

        // The stamp advances at the end of the step_done cycle
        if (done_q) begin
            ts_d = ts_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (step_start) begin
                    spk_lat_d = spk_in;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = (refr_q != '0) ? ST_FIRE : ST_LEAK;
                end
            end
            ST_LEAK: begin
                mem_d   = mem_q - leak_amt;
                idx_d   = '0;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (spk_lat_q[idx_q]) begin
                    mem_d = mem_plus_w;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FIRE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FIRE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                // Refractory step: count down, keep the membrane clamped at 0
                if (refr_q != '0) begin
                    refr_d = refr_q - 1'b1;
                    mem_d  = '0;
                end else if (mem_q >= THRESH_M) begin
                    spk_post_d = 1'b1;
                    mem_d      = '0;
                    refr_d     = REFR_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any step in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            spk_lat_q  <= '0;
            mem_q      <= '0;
            refr_q     <= '0;
            ts_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spk_post_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spk_lat_q  <= spk_lat_d;
            mem_q      <= mem_d;
            refr_q     <= refr_d;
            ts_q       <= ts_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spk_post_q <= spk_post_d;
        end
    end

    assign busy      = busy_q;
    assign step_done = done_q;
    assign spk_post  = spk_post_q;
    assign time_step = ts_q;
    assign membrane  = mem_q;

endmodule : lif_neuron_core

// File: tb/tb_lif_neuron_core.sv
// Testbench for lif_neuron_core. Expected values follow the leak setting the
// bench is compiled with (LIF_LEAK_EN defined or not).
module tb_lif_neuron_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (default parameters) ----------------
    logic         step_start = 1'b0;
    logic [7:0]   spk_in = 8'h00;
    logic [127:0] weights;
    logic         busy, step_done, spk_post;
    logic [7:0]   time_step;
    logic [23:0]  membrane;

    lif_neuron_core u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_start (step_start),
        .spk_in     (spk_in),
        .weights    (weights),
        .busy       (busy),
        .step_done  (step_done),
        .spk_post   (spk_post),
        .time_step  (time_step),
        .membrane   (membrane)
    );

    // ---------------- saturation DUT (MEM_SIZE = 18) ----------------
    logic         s_start = 1'b0;
    logic [7:0]   s_spk = 8'h00;
    logic [127:0] s_weights;
    logic         s_busy, s_done, s_spk_post;
    logic [7:0]   s_ts;
    logic [17:0]  s_mem;

    lif_neuron_core #(.MEM_SIZE(18)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_start (s_start),
        .spk_in     (s_spk),
        .weights    (s_weights),
        .busy       (s_busy),
        .step_done  (s_done),
        .spk_post   (s_spk_post),
        .time_step  (s_ts),
        .membrane   (s_mem)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver: one full step on the main DUT ----------------
    // Starts in a cycle just after a rising edge (cycle 0), returns in the
    // step_done cycle. lat is the cycle number in which step_done is seen;
    // m_fire is the membrane one cycle earlier (the FIRE cycle).
    task automatic run_step(input logic [7:0] spk, output int lat, output logic sp,
                            output logic [7:0] ts, output logic [23:0] m_fire,
                            output logic [23:0] m_done);
        logic [23:0] prev;
        spk_in     = spk;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        lat = 1;
        check("busy_after_accept", busy, 1);
        prev = membrane;
        while (step_done !== 1'b1 && lat < 40) begin
            prev = membrane;
            @(posedge clk); #1;
            lat++;
        end
        sp     = spk_post;
        ts     = time_step;
        m_fire = prev;
        m_done = membrane;
        check("busy_low_at_done", busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  spk;
        int          lat;
        logic        sp;
        logic [7:0]  ts;
        logic [23:0] m_fire;
        logic [23:0] m_done;
    } vec_t;

    vec_t vecs [6];

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int          lat;
        logic        sp;
        logic [7:0]  ts;
        logic [23:0] mf, md;
        int          cyc;
        int          dones;

        weights   = {96'h0, 16'd200, 16'd300};
        s_weights = {8{16'hFFFF}};

`ifdef LIF_LEAK_EN
        vecs[0] = '{8'h03, 11, 1'b0, 8'd0, 24'd500,  24'd500};
        vecs[1] = '{8'h03, 11, 1'b0, 8'd1, 24'd938,  24'd938};
        vecs[2] = '{8'h03, 11, 1'b1, 8'd2, 24'd1321, 24'd0};
        vecs[3] = '{8'hFF, 2,  1'b0, 8'd3, 24'd0,    24'd0};
        vecs[4] = '{8'hFF, 2,  1'b0, 8'd4, 24'd0,    24'd0};
        vecs[5] = '{8'hFF, 11, 1'b0, 8'd5, 24'd500,  24'd500};
`else
        vecs[0] = '{8'h03, 11, 1'b0, 8'd0, 24'd500,  24'd500};
        vecs[1] = '{8'h03, 11, 1'b1, 8'd1, 24'd1000, 24'd0};
        vecs[2] = '{8'hFF, 2,  1'b0, 8'd2, 24'd0,    24'd0};
        vecs[3] = '{8'hFF, 2,  1'b0, 8'd3, 24'd0,    24'd0};
        vecs[4] = '{8'hFF, 11, 1'b0, 8'd4, 24'd500,  24'd500};
        vecs[5] = '{8'h03, 11, 1'b1, 8'd5, 24'd1000, 24'd0};
`endif

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_spk_post", spk_post, 0);
        check("rst_time_step", time_step, 0);
        check("rst_membrane", membrane, 0);
        check("rst_sat_membrane", s_mem, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // One empty step so time_step is non-zero before the mid-step reset
        run_step(8'h00, lat, sp, ts, mf, md);
        check("empty_step_latency", lat, 11);
        check("empty_step_ts", ts, 0);
        @(posedge clk); #1;
        check("ts_after_first_step", time_step, 1);

        // Mid-step reset: asserted in cycle 5 of a step
        spk_in     = 8'h03;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mem_before_reset", membrane, 500);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_membrane", membrane, 0);
        check("midrst_time_step", time_step, 0);
        check("midrst_step_done", step_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Integrate, fire, refractory: back-to-back steps from the table
        for (int i = 0; i < 6; i++) begin
            run_step(vecs[i].spk, lat, sp, ts, mf, md);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_spk_post", i), sp, vecs[i].sp);
            check($sformatf("vec%0d_time_step", i), ts, vecs[i].ts);
            check($sformatf("vec%0d_mem_fire", i), mf, vecs[i].m_fire);
            check($sformatf("vec%0d_mem_done", i), md, vecs[i].m_done);
        end

        // Handshake: step_start held high, one step per 11 cycles, 256 steps
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        spk_in     = 8'h00;
        step_start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (step_done !== 1'b1 && cyc < 20);
            if (k == 255) step_start = 1'b0;
            check($sformatf("held_interval_%0d", k), cyc, 11);
            check($sformatf("held_ts_%0d", k), time_step, k);
        end
        @(posedge clk); #1;
        check("ts_wrap_to_zero", time_step, 0);
        check("held_end_busy", busy, 0);

        // Extra step_start pulse while busy must be dropped
        spk_in     = 8'h03;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        dones = 0;
        for (int c = 2; c <= 26; c++) begin
            @(posedge clk); #1;
            if (c == 4) step_start = 1'b1;
            if (c == 5) step_start = 1'b0;
            if (step_done === 1'b1) dones++;
        end
        check("ignored_pulse_done_count", dones, 1);
        check("ignored_pulse_busy", busy, 0);
        check("ignored_pulse_membrane", membrane, 500);

        // Saturation on the 18-bit instance
        s_spk   = 8'hFF;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 6)  check("sat_pre_clamp", s_mem, 262140);
            if (c == 7)  check("sat_clamped", s_mem, 262143);
            if (c == 10) check("sat_fire_cycle_mem", s_mem, 262143);
            if (c == 11) begin
                check("sat_done", s_done, 1);
                check("sat_spk_post", s_spk_post, 1);
                check("sat_mem_after_fire", s_mem, 0);
                check("sat_time_step", s_ts, 0);
            end
            if (c < 11) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lif_neuron_core
